// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one memory bus port between instruction fetch and the
// memory stage; one transaction in flight, data-first with a bounded fetch starvation guard.
module mem_bus_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  output logic        fetch_error,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_strb,
  output logic        data_ready,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);

  state_t     state_reg;
  logic       grant_reg;
  logic [3:0] streak_reg;
  logic       force_fetch;
  logic       data_wins;

  // Fetch is forced only when it has been waiting through a full data burst.
  assign force_fetch = fetch_req && (streak_reg == BURST_LIMIT);
  assign data_wins   = data_req && !force_fetch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= 1'b0;
      streak_reg <= 4'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_strb   <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fetch_req || data_req) begin
            mem_req   <= 1'b1;
            state_reg <= REQ;
            if (data_wins) begin
              grant_reg <= 1'b1;
              mem_we    <= data_we;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
              mem_strb  <= data_strb;
              if (!fetch_req) begin
                streak_reg <= 4'd0;
              end else if (streak_reg != BURST_LIMIT) begin
                streak_reg <= streak_reg + 4'd1;
              end
            end else begin
              grant_reg  <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= fetch_addr;
              mem_wdata  <= 32'd0;
              mem_strb   <= 4'b1111;
              streak_reg <= 4'd0;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_ready  = (state_reg == REQ)  && mem_ready  && !grant_reg;
  assign data_ready   = (state_reg == REQ)  && mem_ready  &&  grant_reg;
  assign fetch_rvalid = (state_reg == RESP) && mem_rvalid && !grant_reg;
  assign data_rvalid  = (state_reg == RESP) && mem_rvalid &&  grant_reg;

  // Response payload is shared; only the rvalid strobe selects the consumer.
  assign fetch_rdata = mem_rdata;
  assign fetch_error = mem_error;
  assign data_rdata  = mem_rdata;
  assign data_error  = mem_error;

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected handshakes and
// responses, a negedge monitor pops and compares whenever a ready/rvalid appears.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready, fetch_rvalid, fetch_error;
  logic [31:0] fetch_rdata;
  logic        data_req, data_we;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_strb;
  logic        data_ready, data_rvalid, data_error;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_ready, mem_rvalid, mem_error;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        bus_fixed_en;
  logic [31:0] bus_fixed;

  localparam logic [31:0] SCRAMBLE = 32'hA5A5_0000;

  // Memory model: read data is the address scrambled, unless a fixed word is forced.
  assign mem_rdata = bus_fixed_en ? bus_fixed : (mem_addr ^ SCRAMBLE);

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_error(fetch_error),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_strb(data_strb), .data_ready(data_ready),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_error(data_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_error(mem_error), .busy(busy)
  );

  typedef struct {
    logic        is_resp;
    logic        side;     // 0 = fetch, 1 = data
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with no expectation pending (t=%0t)", name, $time);
  endfunction

  function automatic void exp_grant(logic side, logic we, logic [31:0] addr,
                                    logic [31:0] wdata, logic [3:0] strb);
    exp_t e;
    e.is_resp = 1'b0; e.side = side; e.we = we; e.addr = addr;
    e.wdata = wdata; e.strb = strb; e.rdata = 32'd0; e.err = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_resp(logic side, logic [31:0] rdata, logic err);
    exp_t e;
    e.is_resp = 1'b1; e.side = side; e.we = 1'b0; e.addr = 32'd0;
    e.wdata = 32'd0; e.strb = 4'd0; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (fetch_ready || data_ready) begin
        check("ready_exclusive", 32'(fetch_ready && data_ready), 32'd0);
        if (exp_q.size() == 0) fail_now("unexpected_ready");
        else begin
          e = exp_q.pop_front();
          check("ready_kind", 32'(e.is_resp), 32'd0);
          check("ready_side", 32'(data_ready), 32'(e.side));
          check("ready_mem_req", 32'(mem_req), 32'd1);
          check("ready_mem_addr", mem_addr, e.addr);
          check("ready_mem_we", 32'(mem_we), 32'(e.we));
          check("ready_mem_wdata", mem_wdata, e.wdata);
          check("ready_mem_strb", 32'(mem_strb), 32'(e.strb));
          $display("ready  side=%0d addr=0x%08h we=%0d wdata=0x%08h strb=0x%0h",
                   data_ready, mem_addr, mem_we, mem_wdata, mem_strb);
        end
      end
      if (fetch_rvalid || data_rvalid) begin
        check("rvalid_exclusive", 32'(fetch_rvalid && data_rvalid), 32'd0);
        if (exp_q.size() == 0) fail_now("unexpected_rvalid");
        else begin
          e = exp_q.pop_front();
          check("rvalid_kind", 32'(e.is_resp), 32'd1);
          check("rvalid_side", 32'(data_rvalid), 32'(e.side));
          check("rvalid_rdata", data_rvalid ? data_rdata : fetch_rdata, e.rdata);
          check("rvalid_error", 32'(data_rvalid ? data_error : fetch_error), 32'(e.err));
          $display("rvalid side=%0d rdata=0x%08h err=%0d", data_rvalid,
                   data_rvalid ? data_rdata : fetch_rdata,
                   data_rvalid ? data_error : fetch_error);
        end
      end
    end
  end

  task automatic wait_hs(output logic side);
    bit seen = 1'b0;
    side = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (fetch_ready || data_ready) begin
        seen = 1'b1;
        side = data_ready;
      end
    end
    check("handshake_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic drive_data(int k);
    data_we    = k[0];
    data_addr  = 32'h3000 + 32'(4 * k);
    data_wdata = 32'hCAFE_0000 | 32'(k);
    data_strb  = 4'(k + 1);
  endtask

  initial begin
    logic side;
    int dk, fk;
    reset = 1'b1;
    fetch_req = 0; fetch_addr = 0;
    data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0; data_strb = 0;
    mem_ready = 1; mem_rvalid = 1; mem_error = 0;
    bus_fixed_en = 0; bus_fixed = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_strb", 32'(mem_strb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_readies", 32'({fetch_ready, data_ready, fetch_rvalid, data_rvalid}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single fetch, 0-wait bus, fixed instruction word
    bus_fixed_en = 1; bus_fixed = 32'h0000_0013;
    exp_grant(1'b0, 1'b0, 32'h100, 32'd0, 4'hF);
    exp_resp(1'b0, 32'h13, 1'b0);
    fetch_req = 1; fetch_addr = 32'h100;
    wait_hs(side);
    @(posedge clk); #1 fetch_req = 0;
    wait_idle();
    bus_fixed_en = 0;

    // Simultaneous fetch + store: data first, fetch next
    exp_grant(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3);
    exp_resp(1'b1, 32'hA5A5_2000, 1'b0);
    exp_grant(1'b0, 1'b0, 32'h104, 32'd0, 4'hF);
    exp_resp(1'b0, 32'hA5A5_0104, 1'b0);
    @(posedge clk); #1;
    fetch_req = 1; fetch_addr = 32'h104;
    data_req = 1; data_we = 1; data_addr = 32'h2000; data_wdata = 32'hDEADBEEF; data_strb = 4'h3;
    for (int i = 0; i < 2; i++) begin
      wait_hs(side);
      @(posedge clk); #1;
      if (side) data_req = 0; else fetch_req = 0;
    end
    wait_idle();

    // Starvation guard: D,D,D,D,F,D,D,D,D,F with both requests held
    dk = 0; fk = 0;
    for (int g = 0; g < 10; g++) begin
      if (g % 5 == 4) begin
        exp_grant(1'b0, 1'b0, 32'h400 + 32'(4 * fk), 32'd0, 4'hF);
        exp_resp(1'b0, (32'h400 + 32'(4 * fk)) ^ SCRAMBLE, 1'b0);
        fk++;
      end else begin
        exp_grant(1'b1, dk[0], 32'h3000 + 32'(4 * dk), 32'hCAFE_0000 | 32'(dk), 4'(dk + 1));
        exp_resp(1'b1, (32'h3000 + 32'(4 * dk)) ^ SCRAMBLE, 1'b0);
        dk++;
      end
    end
    dk = 0; fk = 0;
    @(posedge clk); #1;
    drive_data(dk); fetch_addr = 32'h400;
    data_req = 1; fetch_req = 1;
    for (int g = 0; g < 10; g++) begin
      wait_hs(side);
      @(posedge clk); #1;
      if (g == 9) begin
        data_req = 0; fetch_req = 0;
      end else if (side) begin
        dk++; drive_data(dk);
      end else begin
        fk++; fetch_addr = 32'h400 + 32'(4 * fk);
      end
    end
    wait_idle();

    // Bus stalls for 5 cycles in REQ
    mem_ready = 0;
    exp_grant(1'b1, 1'b0, 32'h5000, 32'h0000_5555, 4'hF);
    exp_resp(1'b1, 32'hA5A5_5000, 1'b0);
    @(posedge clk); #1;
    data_req = 1; data_we = 0; data_addr = 32'h5000; data_wdata = 32'h0000_5555; data_strb = 4'hF;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_mem_req", 32'(mem_req), 32'd1);
      check("stall_mem_addr", mem_addr, 32'h5000);
      check("stall_no_ready", 32'({fetch_ready, data_ready}), 32'd0);
    end
    @(posedge clk); #1 mem_ready = 1;
    wait_hs(side);
    @(posedge clk); #1 data_req = 0;
    wait_idle();

    // Bus error on a data load
    bus_fixed_en = 1; bus_fixed = 32'hFFFF_FFFF; mem_error = 1;
    exp_grant(1'b1, 1'b0, 32'h6000, 32'd0, 4'hF);
    exp_resp(1'b1, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    data_req = 1; data_we = 0; data_addr = 32'h6000; data_wdata = 0; data_strb = 4'hF;
    wait_hs(side);
    @(posedge clk); #1 data_req = 0;
    wait_idle();
    check("error_back_to_idle", 32'(busy), 32'd0);
    bus_fixed_en = 0; mem_error = 0;

    // Asynchronous reset while waiting in RESP
    mem_rvalid = 0;
    exp_grant(1'b0, 1'b0, 32'h700, 32'd0, 4'hF);
    @(posedge clk); #1;
    fetch_req = 1; fetch_addr = 32'h700;
    wait_hs(side);
    @(posedge clk); #1 fetch_req = 0;
    @(negedge clk);
    check("resp_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'd0);
    mem_rvalid = 1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rvalid_ignored", 32'({fetch_rvalid, data_rvalid}), 32'd0);
      check("late_rvalid_idle", 32'(busy), 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
